// File: rtl/led_display_row_fetch.sv
// led_display_row_fetch: fetches double-rows from a single-port frame RAM and presents them on a valid/ready row interface.
// row_out layout: field k (k = RAM data bit: r/g/b top, r/g/b bottom) occupies bits [k*NUM_COL_PIXELS +: NUM_COL_PIXELS], bit c = column c.
module led_display_row_fetch #(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int NUM_COL_PIXELS = 64,
  parameter int NUM_ROW_PIXELS = 32,
  localparam int ADDR_W = $clog2(NUM_ROW_PIXELS / 2),
  localparam int COL_W  = $clog2(NUM_COL_PIXELS),
  localparam int ROW_W  = 6 * NUM_COL_PIXELS
) (
  input  logic                    clk_in,
  input  logic                    n_reset_in,
  input  logic                    enable_in,
  output logic                    ram_rd_en_out,
  output logic [ADDR_W+COL_W-1:0] ram_addr_out,
  input  logic [5:0]              ram_data_in,
  output logic [ROW_W-1:0]        row_out,
  output logic                    row_valid_out,
  input  logic                    row_ready_in,
  output logic [ADDR_W-1:0]       row_address_out,
  output logic                    frame_done_out
);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(NUM_COL_PIXELS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROW_PIXELS / 2 - 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FULL} state_t;
  state_t              state_q;
  logic [ADDR_W-1:0]   fetch_row_q;
  logic                cap_en_q;
  logic [COL_W-1:0]    cap_col_q;
  logic [NUM_COL_PIXELS-1:0] asm_q [0:5];
  logic [COL_W-1:0]    col;
  logic [COL_W-1:0]    next_col;
  logic                start;
  logic                transfer;
  logic                load;
  assign col      = ram_addr_out[COL_W-1:0];
  assign next_col = ram_rd_en_out ? col + COL_W'(1) : '0;
  assign start    = enable_in && (SYS_CLK_FREQ > 0);
  assign transfer = row_valid_out && row_ready_in;
  assign load     = (state_q == FULL) && (!row_valid_out || row_ready_in);
  // Fetch sequencer: one read per column, then hold the finished row until the output register can take it
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q       <= IDLE;
      fetch_row_q   <= '0;
      ram_rd_en_out <= 1'b0;
      ram_addr_out  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q       <= FETCH;
          ram_rd_en_out <= 1'b1;
          ram_addr_out  <= {fetch_row_q, {COL_W{1'b0}}};
        end
        FETCH: if (ram_rd_en_out && col == LAST_COL) begin
          ram_rd_en_out <= 1'b0;
          state_q       <= DRAIN;
        end else begin
          ram_rd_en_out <= 1'b1;
          ram_addr_out  <= {fetch_row_q, next_col};
        end
        DRAIN: state_q <= FULL;
        FULL: if (load) begin
          fetch_row_q <= fetch_row_q == LAST_ROW ? '0 : fetch_row_q + ADDR_W'(1);
          state_q     <= start ? FETCH : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Read data is valid one cycle after the read; remember which column it belongs to
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      cap_en_q  <= 1'b0;
      cap_col_q <= '0;
    end else begin
      cap_en_q  <= ram_rd_en_out;
      cap_col_q <= col;
    end
  end
  // Scatter each RAM word into its column of all six colour fields
  always_ff @(posedge clk_in) begin
    for (int k = 0; k < 6; k++)
      if (cap_en_q) asm_q[k][cap_col_q] <= ram_data_in[k];
  end
  // Output register: load a finished row, drop valid on a transfer without a replacement
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      row_out         <= '0;
      row_valid_out   <= 1'b0;
      row_address_out <= '0;
      frame_done_out  <= 1'b0;
    end else begin
      frame_done_out <= transfer && row_address_out == LAST_ROW;
      if (load) begin
        row_valid_out   <= 1'b1;
        row_out         <= {asm_q[5], asm_q[4], asm_q[3], asm_q[2], asm_q[1], asm_q[0]};
        row_address_out <= fetch_row_q;
      end else if (transfer) begin
        row_valid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_led_display_row_fetch.sv
// tb_led_display_row_fetch: directed scenarios against a 1-cycle-latency frame RAM model holding (row*7+col) mod 64
module tb_led_display_row_fetch;
  logic         clk_in = 1'b0;
  logic         n_reset_in = 1'b0;
  logic         enable_in = 1'b0;
  logic         row_ready_in = 1'b0;
  logic         ram_rd_en_out;
  logic [9:0]   ram_addr_out;
  logic [5:0]   ram_data_in = '0;
  logic [383:0] row_out;
  logic         row_valid_out;
  logic [3:0]   row_address_out;
  logic         frame_done_out;
  int checks = 0;
  int errors = 0;
  int next_row = 0;

  always #5 clk_in = ~clk_in;

  led_display_row_fetch dut (
    .clk_in(clk_in), .n_reset_in(n_reset_in), .enable_in(enable_in),
    .ram_rd_en_out(ram_rd_en_out), .ram_addr_out(ram_addr_out), .ram_data_in(ram_data_in),
    .row_out(row_out), .row_valid_out(row_valid_out), .row_ready_in(row_ready_in),
    .row_address_out(row_address_out), .frame_done_out(frame_done_out)
  );

  function automatic logic [5:0] word(int r, int c);
    return 6'((r * 7 + c) % 64);
  endfunction

  function automatic logic [383:0] exp_row(int r);
    logic [383:0] e;
    logic [5:0] w;
    e = '0;
    for (int c = 0; c < 64; c++) begin
      w = word(r, c);
      for (int k = 0; k < 6; k++) e[k * 64 + c] = w[k];
    end
    return e;
  endfunction

  always @(posedge clk_in)
    if (ram_rd_en_out) ram_data_in <= word(int'(ram_addr_out[9:6]), int'(ram_addr_out[5:0]));

  task automatic test_reset();
    n_reset_in = 1'b0; enable_in = 1'b0; row_ready_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++; if (ram_rd_en_out !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", ram_rd_en_out); end
    checks++; if (ram_addr_out !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", ram_addr_out); end
    checks++; if (row_out !== 384'd0) begin errors++; $display("FAIL reset_row got %h want 0", row_out); end
    checks++; if (row_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", row_valid_out); end
    checks++; if (row_address_out !== 4'd0) begin errors++; $display("FAIL reset_row_addr got %0d want 0", row_address_out); end
    checks++; if (frame_done_out !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done_out); end
    n_reset_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_first_row();
    int n = 0;
    enable_in = 1'b1;
    while (row_valid_out !== 1'b1 && n < 300) begin @(negedge clk_in); n++; end
    checks++; if (n - 1 != 66) begin errors++; $display("FAIL first_latency got %0d want 66", n - 1); end
    checks++; if (row_address_out !== 4'd0) begin errors++; $display("FAIL first_addr got %0d want 0", row_address_out); end
    checks++; if (row_out !== exp_row(0)) begin errors++; $display("FAIL first_data got %h want %h", row_out, exp_row(0)); end
    next_row = 0;
  endtask

  task automatic test_ready_hold();
    logic [383:0] r0;
    int rd = 0;
    int bad = 0;
    r0 = row_out;
    repeat (500) begin
      @(negedge clk_in);
      if (ram_rd_en_out === 1'b1) begin rd++; if (ram_addr_out[9:6] !== 4'd1) bad++; end
      if (row_valid_out !== 1'b1 || row_out !== r0 || row_address_out !== 4'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    checks++; if (rd != 64) begin errors++; $display("FAIL hold_reads got %0d want 64", rd); end
    checks++; if (ram_rd_en_out !== 1'b0) begin errors++; $display("FAIL hold_rd_idle got %b want 0", ram_rd_en_out); end
    row_ready_in = 1'b1;
    @(negedge clk_in);
    checks++; if (row_valid_out !== 1'b1 || row_address_out !== 4'd1) begin errors++; $display("FAIL release_row1 got v=%b a=%0d want v=1 a=1", row_valid_out, row_address_out); end
    checks++; if (row_out !== exp_row(1)) begin errors++; $display("FAIL release_data got %h want %h", row_out, exp_row(1)); end
    next_row = 1;
  endtask

  task automatic test_frame();
    int xfers = 0;
    int n = 0;
    int last = -1;
    int gap_bad = 0;
    logic pend = 1'b0;
    row_ready_in = 1'b1;
    while (xfers < 16 && n < 2000) begin
      checks++; if (frame_done_out !== pend) begin errors++; $display("FAIL frame_done got %b want %b at cycle %0d", frame_done_out, pend, n); end
      pend = 1'b0;
      if (row_valid_out === 1'b1) begin
        checks++;
        if (row_address_out !== 4'(next_row) || row_out !== exp_row(next_row)) begin
          errors++; $display("FAIL frame_row got a=%0d want a=%0d (data ok=%b)", row_address_out, next_row, row_out === exp_row(next_row));
        end
        if (last >= 0 && n - last != 67) gap_bad++;
        last = n;
        pend = (next_row == 15);
        next_row = (next_row + 1) % 16;
        xfers++;
      end
      @(negedge clk_in); n++;
    end
    checks++; if (xfers != 16) begin errors++; $display("FAIL frame_xfers got %0d want 16", xfers); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL frame_gap got %0d bad gaps want 0", gap_bad); end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    int rd = 0;
    row_ready_in = 1'b1;
    while (!(ram_rd_en_out === 1'b1 && ram_addr_out === {4'd3, 6'd10}) && n < 400) begin
      if (row_valid_out === 1'b1) begin
        checks++;
        if (row_address_out !== 4'(next_row) || row_out !== exp_row(next_row)) begin
          errors++; $display("FAIL drop_pre_row got a=%0d want a=%0d", row_address_out, next_row);
        end
        next_row = (next_row + 1) % 16;
      end
      @(negedge clk_in); n++;
    end
    enable_in = 1'b0;
    n = 0;
    while (row_valid_out !== 1'b1 && n < 200) begin @(negedge clk_in); n++; end
    checks++; if (row_address_out !== 4'd3 || row_out !== exp_row(3)) begin errors++; $display("FAIL drop_row3 got a=%0d v=%b want a=3 v=1", row_address_out, row_valid_out); end
    @(negedge clk_in);
    repeat (300) begin if (ram_rd_en_out !== 1'b0) rd++; @(negedge clk_in); end
    checks++; if (rd != 0) begin errors++; $display("FAIL drop_no_reads got %0d reads want 0", rd); end
    checks++; if (row_valid_out !== 1'b0) begin errors++; $display("FAIL drop_valid got %b want 0", row_valid_out); end
    enable_in = 1'b1;
    n = 0;
    while (row_valid_out !== 1'b1 && n < 200) begin @(negedge clk_in); n++; end
    checks++; if (row_address_out !== 4'd4 || row_out !== exp_row(4)) begin errors++; $display("FAIL resume_row got a=%0d v=%b want a=4 v=1", row_address_out, row_valid_out); end
    @(negedge clk_in);
    next_row = 5;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(ram_rd_en_out === 1'b1 && ram_addr_out === {4'd5, 6'd30}) && n < 400) begin @(negedge clk_in); n++; end
    checks++; if (n >= 400) begin errors++; $display("FAIL mid_reach got timeout want row5 col30"); end
    n_reset_in = 1'b0;
    #1;
    checks++; if (ram_rd_en_out !== 1'b0 || ram_addr_out !== 10'd0) begin errors++; $display("FAIL mid_rd got en=%b addr=%0d want 0 0", ram_rd_en_out, ram_addr_out); end
    checks++; if (row_out !== 384'd0 || row_valid_out !== 1'b0) begin errors++; $display("FAIL mid_row got v=%b want 0 and zero row", row_valid_out); end
    checks++; if (row_address_out !== 4'd0 || frame_done_out !== 1'b0) begin errors++; $display("FAIL mid_addr got a=%0d fd=%b want 0 0", row_address_out, frame_done_out); end
    repeat (2) @(negedge clk_in);
    n_reset_in = 1'b1;
    n = 0;
    while (row_valid_out !== 1'b1 && n < 200) begin @(negedge clk_in); n++; end
    checks++; if (n - 1 != 66) begin errors++; $display("FAIL mid_latency got %0d want 66", n - 1); end
    checks++; if (row_address_out !== 4'd0 || row_out !== exp_row(0)) begin errors++; $display("FAIL mid_row0 got a=%0d want a=0", row_address_out); end
    @(negedge clk_in);
    next_row = 1;
  endtask

  task automatic test_random();
    int xfers = 0;
    int n = 0;
    logic hold = 1'b0;
    logic pend = 1'b0;
    logic [383:0] hrow;
    logic [3:0] haddr;
    hrow = '0; haddr = '0;
    while (xfers < 64 && n < 20000) begin
      row_ready_in = 1'($urandom_range(0, 1));
      checks++; if (frame_done_out !== pend) begin errors++; $display("FAIL rand_frame_done got %b want %b at cycle %0d", frame_done_out, pend, n); end
      pend = 1'b0;
      if (hold) begin
        checks++;
        if (row_valid_out !== 1'b1 || row_out !== hrow || row_address_out !== haddr) begin
          errors++; $display("FAIL rand_hold got v=%b a=%0d want v=1 a=%0d", row_valid_out, row_address_out, haddr);
        end
      end
      if (row_valid_out === 1'b1 && row_ready_in) begin
        checks++;
        if (row_address_out !== 4'(next_row) || row_out !== exp_row(next_row)) begin
          errors++; $display("FAIL rand_row got a=%0d want a=%0d", row_address_out, next_row);
        end
        pend = (next_row == 15);
        next_row = (next_row + 1) % 16;
        xfers++;
      end
      hold = (row_valid_out === 1'b1) && !row_ready_in;
      hrow = row_out; haddr = row_address_out;
      @(negedge clk_in); n++;
    end
    checks++; if (xfers != 64) begin errors++; $display("FAIL rand_xfers got %0d want 64", xfers); end
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_ready_hold();
    test_frame();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_display_row_fetch.md
# led_display_row_fetch

Upstream feeder for `led_display_driver_phy`. It fetches one double-row (top half row plus bottom half row) at a time from an external single-port frame RAM and assembles it into an `rgb_row_t`. It then presents the row on the same valid/ready row interface the pattern generator drives. A two-entry buffer (assembly buffer plus output register) lets the fetch of row r+1 overlap the shift-out of row r, so the PHY never stalls on RAM reads.

## Interface
Parameters:
- `SYS_CLK_FREQ`, 100_000_000, system clock frequency in Hz (informational, kept for consistency).
- `NUM_COL_PIXELS`, 64, columns per row; must equal `GL_NUM_COL_PIXELS`.
- `NUM_ROW_PIXELS`, 32, panel rows.
  - Row addresses = `NUM_ROW_PIXELS/2` = 16.
  - `ADDR_W` = clog2(16) = 4.
  - `COL_W` = clog2(64) = 6.

Ports:
- `clk_in` in 1: system clock; all logic runs on its rising edge.
- `n_reset_in` in 1: asynchronous active-low reset.
- `enable_in` in 1: when high, fetching runs continuously; when low, no new row fetch starts.
- `ram_rd_en_out` out 1: frame RAM read enable.
- `ram_addr_out` out ADDR_W+COL_W: RAM word address = {row, col}.
- `ram_data_in` in 6: RAM read data, valid exactly 1 cycle after a read.
  - bit 0 = red top, bit 1 = green top, bit 2 = blue top.
  - bit 3 = red bot, bit 4 = green bot, bit 5 = blue bot.
- `row_out` out `GL_RGB_ROW_W`: assembled row; bit c of each colour field = column c.
- `row_valid_out` out 1: `row_out` and `row_address_out` are valid.
- `row_ready_in` in 1: consumer accepts the row; a transfer occurs when valid and ready are both high at a rising edge.
- `row_address_out` out ADDR_W: row address belonging to `row_out`.
- `frame_done_out` out 1: one-cycle pulse when row 15 transfers.

## Operation
Fetch FSM states and transitions:
- IDLE → FETCH: at an edge where `enable_in` = 1 and the assembly buffer is empty.
- FETCH: issues reads for col 0..NUM_COL_PIXELS-1 on consecutive cycles.
  - `ram_rd_en_out` = 1; `ram_addr_out` = {fetch_row, col}.
  - Goes to DRAIN after col 63 is issued.
- DRAIN: one cycle to capture the last data word; then goes to FULL.
- FULL: the assembly buffer holds a complete row.
  - Moves the buffer to the output register when the output register is empty, or is being transferred in this same cycle.
  - Increments fetch_row (mod 16).
  - Then goes to FETCH if `enable_in` = 1, else to IDLE.

Data capture and output register:
- Each captured `ram_data_in` word writes column (issued col delayed 1 cycle) of all six colour fields in the assembly buffer.
- On load: `row_valid_out` ← 1, `row_out` ← assembly buffer, `row_address_out` ← that row's address.
- On a transfer with no simultaneous load: `row_valid_out` ← 0.
- A simultaneous transfer and load keeps `row_valid_out` high; the new row appears the next cycle.
- `row_out` and `row_address_out` hold stable while valid is high and ready is low.

Row ordering and frame pulse:
- Rows are presented in order 0, 1, …, 15, 0, … with no skips or repeats.
- `frame_done_out` = 1 for exactly the cycle after row 15 transfers.

Enable deassertion:
- Deassertion never aborts a fetch in progress.
- A completed row is still delivered.
- fetch_row is retained; re-enable resumes at the next row, not row 0.

Reset:
- Reset is asynchronous and may occur at any point, including mid-fetch.
- It returns the FSM to IDLE, sets fetch_row = 0 and empties both buffers.
- Reset values: `ram_rd_en_out` 0, `ram_addr_out` 0, `row_out` all zeros, `row_valid_out` 0, `row_address_out` 0, `frame_done_out` 0.

## Timing
- Edge E0 is the edge that samples `enable_in` = 1 in IDLE.
- Read enable: `ram_rd_en_out` is high from E0 through E63, i.e. 64 cycles with col 0..63.
- Data capture: on E1..E64.
- First row: `row_valid_out` rises after E66, i.e. 66 cycles of fetch latency with an empty pipeline.
- Steady state:
  - The next fetch starts the cycle after a load.
  - The following row sits in FULL by 66 cycles after that load.
  - Back-to-back transfers are possible every 67 cycles when ready is held high.
- The PHY needs far more than 67 cycles per row, so the fetch latency is hidden.
- The RAM read latency is fixed at 1 cycle; any other latency is unsupported.

## Test plan
- Frame RAM word = (row*7 + col) mod 64, ready held high, enable = 1.
  - Rows arrive 0..15 then 0 again.
  - Each column matches its RAM word.
  - The first valid appears 66 cycles after enable.
- Ready held low for 500 cycles after the first valid.
  - `row_out` and address 0 stay stable.
  - The assembly buffer fills (row 1) and `ram_rd_en_out` stays 0 after its fetch.
  - On release, row 1 appears on the cycle after the row 0 transfer.
- Enable dropped mid-fetch of row 3.
  - Row 3 is still delivered, and no further reads occur.
  - Re-enable → the next row is 4.
- Full frame with ready = 1.
  - `frame_done_out` pulses exactly once per 16 transfers, the cycle after row 15.
- Reset asserted mid-fetch (col 30 of row 5).
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release + enable, the first row is 0 with correct data.
- Random ready toggling (50%) over 4 frames.
  - No row is lost or duplicated, and data matches the RAM model.
  - Valid never drops without a transfer.
